demux1to2_rx: RTL and testbench
===============================

# demux1to2_rx

Sequential 1-to-2 demultiplexing receiver: the receiving end of the shared line driven by our 2-to-1 mux cells. It accepts words tagged with a select bit from a single valid/ready input stream and steers each word into one of two per-channel FIFOs, each drained by its own valid/ready output. A break-before-make guard cycle on every select change mirrors the non-overlapping switching of the mux side. It sits between the shared neuron-event bus and the two downstream consumers.

## Interface
Parameters:
- DW, 8, data width in bits (1..32)
- DEPTH, 4, entries per channel FIFO (power of two, 2..16)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RSTb  input  1  reset, asynchronous, active-low
- D  input  DW  input data word
- SEL  input  1  destination: 0 -> channel 0, 1 -> channel 1
- D_VLD  input  1  D/SEL valid
- D_RDY  output  1  receiver can accept this cycle
- Y0, Y1  output  DW  head word of channel 0 / 1 FIFO
- Y0_VLD, Y1_VLD  output  1  channel FIFO non-empty
- Y0_RDY, Y1_RDY  input  1  downstream pops head when VLD&RDY
- CNT0, CNT1  output  16  accepted-word counters (only with DEMUX_COUNT_EN)

## Operation
- Transfer in: D_VLD & D_RDY at rising CLK; word pushed into FIFO[SEL].
- Transfer out: Yn_VLD & Yn_RDY at rising CLK; head of FIFO n popped.
- FSM states: IDLE, ROUTE0, ROUTE1, GUARD. Register LAST_SEL tracks current route.
  - IDLE: reset state. D_VLD=1 -> ROUTE<SEL> (word accepted this cycle if FIFO[SEL] not full).
  - ROUTEn: D_VLD=1 & SEL=n -> stay, accept if not full. D_VLD=1 & SEL!=n -> GUARD, nothing accepted. D_VLD=0 -> stay ROUTEn.
  - GUARD: exactly one cycle, D_RDY=0; then ROUTE<SEL sampled at GUARD exit> (SEL of the current cycle).
- D_RDY = (state!=GUARD) & !(D_VLD & SEL!=LAST_SEL & state!=IDLE) & !full[SEL]. D_RDY depends combinationally on SEL/D_VLD; no combinational path from Yn_RDY to D_RDY.
- Full FIFO: push blocked by D_RDY=0 even if same-cycle pop occurs (pop frees space for next cycle only).
- Empty FIFO: Yn_VLD=0, Yn holds last popped value (0 after reset); a pop attempt is ignored.
- Simultaneous push and pop on the same channel, not full: both happen, occupancy unchanged.
- Pointers are log2(DEPTH)+1 bits; wrap naturally; full = MSBs differ, low bits equal.
- Reset (async, any time): state=IDLE, LAST_SEL=0, all FIFO pointers 0, Y0=Y1=0, Y0_VLD=Y1_VLD=0, D_RDY=0 while RSTb=0, CNT0=CNT1=0. Words in flight are discarded.

## Timing
- Latency: word accepted at edge k is visible on Yn with Yn_VLD=1 after edge k (next cycle), if FIFO was empty.
- Throughput: 1 word/cycle while SEL constant and destination not full.
- Select change costs exactly 2 non-accepting cycles: the detect cycle plus GUARD.
- Yn, Yn_VLD are registered outputs (driven from FIFO storage/pointer registers).
- First word after reset: from IDLE, accepted in the first cycle D_VLD=1; no guard.

## Configuration
- DEMUX_COUNT_EN defined: CNT0/CNT1 ports present; each increments by 1 on every accepted word to its channel, saturating at 16'hFFFF, cleared only by reset.
- Not defined: CNT0/CNT1 ports and counter logic absent; all other behaviour identical.

## Test plan
- Reset then D=8'hA5, SEL=0, D_VLD=1 one cycle, Y0_RDY=1 -> D_RDY=1 in that cycle; next cycle Y0=8'hA5, Y0_VLD=1; Y1_VLD stays 0.
- Stream 4 words SEL=1 with Y1_RDY=0, DEPTH=4, 5th offered -> first four accepted on consecutive edges, D_RDY=0 for fifth; raise Y1_RDY -> 5th accepted cycle after first pop, Y1 order 1..5.
- Alternate SEL 0,1,0 with D_VLD=1 continuous -> each switch yields 2 cycles D_RDY=0 (detect, GUARD), words delivered to correct channel in order.
- Push and pop same cycle on channel 0 at occupancy 2 -> occupancy stays 2, Y0 advances to next word.
- Assert RSTb=0 mid-stream with both FIFOs holding 3 words -> immediately Y0_VLD=Y1_VLD=0, Y0=Y1=0, D_RDY=0; after release first word accepted without guard.
- With DEMUX_COUNT_EN: 70000 words to channel 0 -> CNT0=16'hFFFF, CNT1=0.

Source files
------------

// File: rtl/demux1to2_rx_if.sv
// Bus bundle for demux1to2_rx: one tagged input stream, two per-channel output streams.
// CNT0/CNT1 are present only when DEMUX_COUNT_EN is defined.
interface demux1to2_rx_if #(
  parameter int DW = 8
);
  logic [DW-1:0] D;
  logic          SEL;
  logic          D_VLD;
  logic          D_RDY;
  logic [DW-1:0] Y0;
  logic [DW-1:0] Y1;
  logic          Y0_VLD;
  logic          Y1_VLD;
  logic          Y0_RDY;
  logic          Y1_RDY;
`ifdef DEMUX_COUNT_EN
  logic [15:0]   CNT0;
  logic [15:0]   CNT1;
`endif

  // slave: the receiver itself
  modport slave (
    input  D, SEL, D_VLD, Y0_RDY, Y1_RDY,
    output D_RDY, Y0, Y1, Y0_VLD, Y1_VLD
`ifdef DEMUX_COUNT_EN
    , output CNT0, CNT1
`endif
  );

  // master: upstream source plus downstream consumers
  modport master (
    output D, SEL, D_VLD, Y0_RDY, Y1_RDY,
    input  D_RDY, Y0, Y1, Y0_VLD, Y1_VLD
`ifdef DEMUX_COUNT_EN
    , input CNT0, CNT1
`endif
  );
endinterface

// File: rtl/demux1to2_rx.sv
// 1-to-2 demultiplexing receiver with per-channel FIFOs and a break-before-make guard cycle.
// Optional DEMUX_COUNT_EN adds saturating 16-bit accepted-word counters CNT0/CNT1.
//
// state  | meaning
// IDLE   | after reset, no route chosen yet; first word accepted without guard
// ROUTE0 | steering words into channel 0
// ROUTE1 | steering words into channel 1
// GUARD  | one dead cycle between routes, nothing accepted
module demux1to2_rx #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input logic            CLK,
  input logic            RSTb,
  demux1to2_rx_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1, GUARD} state_t;

  state_t     state_q, state_d;
  logic       last_sel_q, last_sel_d;
  logic       d_rdy;
  logic       push_all;
  logic [1:0] push;
  logic [1:0] pop_rdy;
  logic       full_sel;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q    <= IDLE;
      last_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_sel_q <= last_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_sel_d = last_sel_q;
    case (state_q)
      IDLE: begin
        if (bus.D_VLD) begin
          state_d    = bus.SEL ? ROUTE1 : ROUTE0;
          last_sel_d = bus.SEL;
        end
      end
      ROUTE0, ROUTE1: begin
        if (bus.D_VLD && (bus.SEL != last_sel_q)) state_d = GUARD;
      end
      GUARD: begin
        state_d    = bus.SEL ? ROUTE1 : ROUTE0;
        last_sel_d = bus.SEL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready looks only at full flags, never at the downstream ready inputs.
  always_comb begin
    d_rdy = RSTb && (state_q != GUARD) && !full_sel;
    if (bus.D_VLD && (state_q != IDLE) && (bus.SEL != last_sel_q)) d_rdy = 1'b0;
  end

  assign bus.D_RDY = d_rdy;
  assign push_all  = bus.D_VLD & d_rdy;
  assign push      = {push_all & bus.SEL, push_all & ~bus.SEL};
  assign pop_rdy   = {bus.Y1_RDY, bus.Y0_RDY};
  assign full_sel  = bus.SEL ? g_ch[1].full : g_ch[0].full;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [DW-1:0] y_q, y_d;
    logic          vld, full, pop;

    assign vld  = (wr_q != rd_q);
    assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop  = vld & pop_rdy[c];
    assign wr_d = wr_q + {{AW{1'b0}}, push[c]};
    assign rd_d = rd_q + {{AW{1'b0}}, pop};

    // Output register tracks the post-edge head; when the FIFO drains it keeps the last word.
    always_comb begin
      y_d = y_q;
      if (wr_d != rd_d) begin
        if (push[c] && (rd_d == wr_q)) y_d = bus.D;
        else                           y_d = mem_q[rd_d[AW-1:0]];
      end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
        wr_q <= '0;
        rd_q <= '0;
        y_q  <= '0;
      end else begin
        wr_q <= wr_d;
        rd_q <= rd_d;
        y_q  <= y_d;
      end
    end

    always_ff @(posedge CLK) begin
      if (push[c]) mem_q[wr_q[AW-1:0]] <= bus.D;
    end
  end

  assign bus.Y0     = g_ch[0].y_q;
  assign bus.Y1     = g_ch[1].y_q;
  assign bus.Y0_VLD = g_ch[0].vld;
  assign bus.Y1_VLD = g_ch[1].vld;

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (push[0] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (push[1] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign bus.CNT0 = cnt0_q;
  assign bus.CNT1 = cnt1_q;
`endif
endmodule

// File: tb/tb_demux1to2_rx.sv
// Directed self-checking bench for demux1to2_rx (DW=8, DEPTH=4).
module tb_demux1to2_rx;
  logic CLK = 1'b0;
  logic RSTb = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  demux1to2_rx_if #(.DW(8)) bus ();

  demux1to2_rx #(.DW(8), .DEPTH(4)) dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTb = 1'b0;
    bus.D = 8'h11; bus.SEL = 1'b0; bus.D_VLD = 1'b1;
    bus.Y0_RDY = 1'b0; bus.Y1_RDY = 1'b0;
    #3;
    total_cnt++; if (bus.D_RDY !== 1'b0) $display("FAIL rst_d_rdy got %b exp 0", bus.D_RDY); else pass_cnt++;
    total_cnt++; if (bus.Y0_VLD !== 1'b0 || bus.Y1_VLD !== 1'b0) $display("FAIL rst_vld got %b%b exp 00", bus.Y1_VLD, bus.Y0_VLD); else pass_cnt++;
    total_cnt++; if (bus.Y0 !== 8'h00 || bus.Y1 !== 8'h00) $display("FAIL rst_y got %h %h exp 00 00", bus.Y0, bus.Y1); else pass_cnt++;
    tick(); tick();
    bus.D_VLD = 1'b0;
    RSTb = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.D = 8'hA5; bus.SEL = 1'b0; bus.D_VLD = 1'b1; bus.Y0_RDY = 1'b1;
    #2;
    total_cnt++; if (bus.D_RDY !== 1'b1) $display("FAIL single_rdy got %b exp 1", bus.D_RDY); else pass_cnt++;
    tick();
    bus.D_VLD = 1'b0;
    #2;
    total_cnt++; if (bus.Y0 !== 8'hA5 || bus.Y0_VLD !== 1'b1) $display("FAIL single_y0 got %h/%b exp a5/1", bus.Y0, bus.Y0_VLD); else pass_cnt++;
    total_cnt++; if (bus.Y1_VLD !== 1'b0) $display("FAIL single_y1vld got %b exp 0", bus.Y1_VLD); else pass_cnt++;
    tick();
    total_cnt++; if (bus.Y0_VLD !== 1'b0 || bus.Y0 !== 8'hA5) $display("FAIL single_hold got %h/%b exp a5/0", bus.Y0, bus.Y0_VLD); else pass_cnt++;
    bus.Y0_RDY = 1'b0;
  endtask

  // state is ROUTE0 on entry: the switch to SEL=1 first costs detect + guard
  task automatic test_full();
    bus.SEL = 1'b1; bus.D = 8'd1; bus.D_VLD = 1'b1; bus.Y1_RDY = 1'b0;
    #2;
    total_cnt++; if (bus.D_RDY !== 1'b0) $display("FAIL full_detect got %b exp 0", bus.D_RDY); else pass_cnt++;
    tick(); #2;
    total_cnt++; if (bus.D_RDY !== 1'b0) $display("FAIL full_guard got %b exp 0", bus.D_RDY); else pass_cnt++;
    tick();
    for (int i = 1; i <= 4; i++) begin
      bus.D = 8'(i);
      #2;
      total_cnt++; if (bus.D_RDY !== 1'b1) $display("FAIL full_acc%0d got %b exp 1", i, bus.D_RDY); else pass_cnt++;
      tick();
    end
    bus.D = 8'd5;
    #2;
    total_cnt++; if (bus.D_RDY !== 1'b0) $display("FAIL full_block got %b exp 0", bus.D_RDY); else pass_cnt++;
    total_cnt++; if (bus.Y1 !== 8'd1 || bus.Y1_VLD !== 1'b1) $display("FAIL full_head got %h/%b exp 01/1", bus.Y1, bus.Y1_VLD); else pass_cnt++;
    bus.Y1_RDY = 1'b1;
    #1;
    total_cnt++; if (bus.D_RDY !== 1'b0) $display("FAIL full_popsame got %b exp 0", bus.D_RDY); else pass_cnt++;
    tick(); #2;
    total_cnt++; if (bus.D_RDY !== 1'b1 || bus.Y1 !== 8'd2) $display("FAIL full_after_pop got %b/%h exp 1/02", bus.D_RDY, bus.Y1); else pass_cnt++;
    tick();
    bus.D_VLD = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      total_cnt++; if (bus.Y1 !== 8'(k) || bus.Y1_VLD !== 1'b1) $display("FAIL full_order%0d got %h/%b exp %h/1", k, bus.Y1, bus.Y1_VLD, 8'(k)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (bus.Y1_VLD !== 1'b0 || bus.Y1 !== 8'd5) $display("FAIL full_drain got %h/%b exp 05/0", bus.Y1, bus.Y1_VLD); else pass_cnt++;
    bus.Y1_RDY = 1'b0;
  endtask

  // state is ROUTE1 on entry
  task automatic test_alternate();
    logic       sel_v [11] = '{0,0,0,0,1,1,1,1,0,0,0};
    logic [7:0] dat_v [11] = '{8'h10,8'h10,8'h10,8'h11,8'h20,8'h20,8'h20,8'h21,8'h12,8'h12,8'h12};
    logic       rdy_v [11] = '{0,0,1,1,0,0,1,1,0,0,1};
    logic [7:0] exp0  [3]  = '{8'h10, 8'h11, 8'h12};
    logic [7:0] exp1  [2]  = '{8'h20, 8'h21};
    bus.Y0_RDY = 1'b0; bus.Y1_RDY = 1'b0; bus.D_VLD = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.SEL = sel_v[i]; bus.D = dat_v[i];
      #2;
      total_cnt++; if (bus.D_RDY !== rdy_v[i]) $display("FAIL alt_rdy%0d got %b exp %b", i, bus.D_RDY, rdy_v[i]); else pass_cnt++;
      tick();
    end
    bus.D_VLD = 1'b0;
    bus.Y0_RDY = 1'b1; bus.Y1_RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bus.Y0 !== exp0[i] || bus.Y0_VLD !== 1'b1) $display("FAIL alt_y0_%0d got %h/%b exp %h/1", i, bus.Y0, bus.Y0_VLD, exp0[i]); else pass_cnt++;
      if (i < 2) begin
        total_cnt++; if (bus.Y1 !== exp1[i] || bus.Y1_VLD !== 1'b1) $display("FAIL alt_y1_%0d got %h/%b exp %h/1", i, bus.Y1, bus.Y1_VLD, exp1[i]); else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (bus.Y0_VLD !== 1'b0 || bus.Y1_VLD !== 1'b0) $display("FAIL alt_empty got %b%b exp 00", bus.Y1_VLD, bus.Y0_VLD); else pass_cnt++;
    bus.Y0_RDY = 1'b0; bus.Y1_RDY = 1'b0;
  endtask

  // state is ROUTE0 on entry
  task automatic test_push_pop();
    bus.SEL = 1'b0; bus.D_VLD = 1'b1; bus.Y0_RDY = 1'b0;
    bus.D = 8'h30; tick();
    bus.D = 8'h31; tick();
    bus.D = 8'h32; bus.Y0_RDY = 1'b1;
    #2;
    total_cnt++; if (bus.D_RDY !== 1'b1) $display("FAIL pp_rdy got %b exp 1", bus.D_RDY); else pass_cnt++;
    tick();
    bus.D_VLD = 1'b0;
    total_cnt++; if (bus.Y0 !== 8'h31 || bus.Y0_VLD !== 1'b1) $display("FAIL pp_adv got %h/%b exp 31/1", bus.Y0, bus.Y0_VLD); else pass_cnt++;
    tick();
    total_cnt++; if (bus.Y0 !== 8'h32 || bus.Y0_VLD !== 1'b1) $display("FAIL pp_second got %h/%b exp 32/1", bus.Y0, bus.Y0_VLD); else pass_cnt++;
    tick();
    total_cnt++; if (bus.Y0_VLD !== 1'b0) $display("FAIL pp_occ got vld %b exp 0", bus.Y0_VLD); else pass_cnt++;
    bus.Y0_RDY = 1'b0;
  endtask

  // state is ROUTE0 on entry
  task automatic test_reset_mid();
    bus.Y0_RDY = 1'b0; bus.Y1_RDY = 1'b0;
    bus.SEL = 1'b0; bus.D_VLD = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.D = 8'h40 + 8'(i); tick(); end
    bus.SEL = 1'b1; bus.D = 8'h50;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin bus.D = 8'h50 + 8'(i); tick(); end
    bus.D = 8'h53;
    #1;
    total_cnt++; if (bus.Y0 !== 8'h40 || bus.Y1 !== 8'h50 || bus.Y0_VLD !== 1'b1 || bus.Y1_VLD !== 1'b1)
      $display("FAIL rm_fill got %h/%b %h/%b exp 40/1 50/1", bus.Y0, bus.Y0_VLD, bus.Y1, bus.Y1_VLD); else pass_cnt++;
    RSTb = 1'b0;
    #1;
    total_cnt++; if (bus.Y0_VLD !== 1'b0 || bus.Y1_VLD !== 1'b0) $display("FAIL rm_vld got %b%b exp 00", bus.Y1_VLD, bus.Y0_VLD); else pass_cnt++;
    total_cnt++; if (bus.Y0 !== 8'h00 || bus.Y1 !== 8'h00) $display("FAIL rm_y got %h %h exp 00 00", bus.Y0, bus.Y1); else pass_cnt++;
    total_cnt++; if (bus.D_RDY !== 1'b0) $display("FAIL rm_rdy got %b exp 0", bus.D_RDY); else pass_cnt++;
    tick();
    RSTb = 1'b1; bus.D = 8'h60;
    #2;
    total_cnt++; if (bus.D_RDY !== 1'b1) $display("FAIL rm_first got %b exp 1", bus.D_RDY); else pass_cnt++;
    tick();
    bus.D_VLD = 1'b0;
    total_cnt++; if (bus.Y1 !== 8'h60 || bus.Y1_VLD !== 1'b1 || bus.Y0_VLD !== 1'b0)
      $display("FAIL rm_deliver got %h/%b y0vld %b exp 60/1 0", bus.Y1, bus.Y1_VLD, bus.Y0_VLD); else pass_cnt++;
    bus.Y1_RDY = 1'b1; tick(); bus.Y1_RDY = 1'b0;
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_count();
    total_cnt++; if (bus.CNT0 !== 16'd0 || bus.CNT1 !== 16'd1) $display("FAIL cnt_pre got %0d %0d exp 0 1", bus.CNT0, bus.CNT1); else pass_cnt++;
    RSTb = 1'b0; #1;
    total_cnt++; if (bus.CNT1 !== 16'd0) $display("FAIL cnt_rst got %0d exp 0", bus.CNT1); else pass_cnt++;
    tick(); RSTb = 1'b1;
    bus.SEL = 1'b0; bus.D = 8'h77; bus.D_VLD = 1'b1; bus.Y0_RDY = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    total_cnt++; if (bus.CNT0 !== 16'd100) $display("FAIL cnt_100 got %0d exp 100", bus.CNT0); else pass_cnt++;
    for (int i = 100; i < 70000; i++) tick();
    bus.D_VLD = 1'b0;
    total_cnt++; if (bus.CNT0 !== 16'hFFFF || bus.CNT1 !== 16'd0) $display("FAIL cnt_sat got %h %h exp ffff 0000", bus.CNT0, bus.CNT1); else pass_cnt++;
    bus.Y0_RDY = 1'b0;
  endtask
`endif

  initial begin
    bus.D = '0; bus.SEL = 1'b0; bus.D_VLD = 1'b0; bus.Y0_RDY = 1'b0; bus.Y1_RDY = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_alternate();
    test_push_pop();
    test_reset_mid();
`ifdef DEMUX_COUNT_EN
    test_count();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
